mdu_issue: RTL and testbench
============================

MDU_ISSUE -- requirements
Module: mdu_issue

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset; clock clk.
REQ-003 SHALL have port: flush  in  1  drop held request (pipeline flush).
REQ-004 SHALL have port: req_valid  in  1  E-stage MDU request.
REQ-005 SHALL have port: req_op  in  4  1 mult, 2 multu, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 div, 8 divu.
REQ-006 SHALL have ports: req_d1 and req_d2, each in 32, operands.
REQ-007 SHALL have port: req_ready  out  1  = !pend_valid && !flush.
REQ-008 SHALL have ports: mdu_start out 1, mdu_op out 4, mdu_d1 out 32, mdu_d2 out 32, all to the MDU.
REQ-009 SHALL have ports: mdu_busy in 1, mdu_out in 32, both from the MDU.
REQ-010 SHALL have ports: rd_data out 32 (registered mfhi/mflo result), rd_valid out 1 (one-cycle pulse), stall out 1 (= pend_valid).
REQ-011 SHALL have port: dz_err  out  1  divide-by-zero pulse (see Configuration).

Function
REQ-012 SHALL hold one request in pend_valid/pend_op/pend_d1/pend_d2; accept on req_valid && req_ready.
REQ-013 SHALL accept ops 0 and 9-15 without storing them or producing any effect.
REQ-014 SHALL use FSM states IDLE (no pending), PEND (pending), RDOUT (rd_valid cycle); PEND->IDLE or RDOUT on issue, RDOUT->IDLE or PEND after 1 cycle.
REQ-015 SHALL drive issue = pend_valid && !mdu_busy && !flush (combinational).
REQ-016 SHALL drive mdu_op/mdu_d1/mdu_d2 from pend_* when pend_valid, else 0.
REQ-017 SHALL assert mdu_start = issue for ops 1,2,3,4,7,8; mdu_start SHALL be 0 for ops 5,6.
REQ-018 SHALL clear pend_valid at the edge ending the issue cycle; minimum latency: accepted at edge N, issued in cycle N+1.
REQ-019 SHALL, for ops 5/6, capture mdu_out into rd_data at the issue edge and hold rd_valid=1 for exactly the next cycle; rd_data SHALL otherwise hold.
REQ-020 SHALL hold a pending request while mdu_busy=1 (any op, including 5/6) with stall=1.
REQ-021 SHALL, when flush=1, clear pend_valid, suppress issue and refuse new requests that cycle; an rd_valid already scheduled SHALL still occur.
REQ-022 SHALL accept a new request in the same cycle rd_valid is high.

Reset
REQ-023 SHALL clear on reset: state=IDLE, pend_*=0, rd_data=0, rd_valid=0, dz_err=0; mdu_start, stall =0; reset SHALL override flush and req_valid.
REQ-024 SHALL discard a pending request when reset arrives mid-wait.

Configuration
REQ-025 SHALL, with MDU_DIVZERO_CHECK_EN defined, not store op 7/8 with req_d2==0, not start the MDU for it, and pulse dz_err for one cycle after the accepting edge.
REQ-026 SHALL, without MDU_DIVZERO_CHECK_EN, tie dz_err to 0 and issue divides by zero normally.

Verification
REQ-027 SHALL cover: mult 3 * -2 while idle -> mdu_start high for 1 cycle in cycle N+1, mdu_op=1, stall high 1 cycle.
REQ-028 SHALL cover: mflo requested while mdu_busy=1 for 4 cycles -> stall for 4 cycles, no mdu_start, rd_valid=1 with rd_data=mdu_out (0xFFFFFFFA) one cycle after busy falls.
REQ-029 SHALL cover: flush asserted during a held divu -> pend cleared, no mdu_start ever, req_ready=0 that cycle.
REQ-030 SHALL cover: reset pulsed while div is pending -> all outputs 0 next cycle, no start.
REQ-031 SHALL cover: div 7/0 with macro defined -> dz_err=1 for 1 cycle, no start; without macro -> mdu_start=1.
REQ-032 SHALL cover: mthi then mfhi back-to-back -> mdu_start for op 3 only, then rd_valid on the following issue.

Source files
------------

// File: rtl/mdu_issue_if.sv
// mdu_issue_if: E-stage request channel into the MDU issue stage.
//   req_valid  requester -> issue stage, request present
//   req_op     requester -> issue stage, MDU opcode (4 bits)
//   req_d1     requester -> issue stage, operand 1 (32 bits)
//   req_d2     requester -> issue stage, operand 2 (32 bits)
//   req_ready  issue stage -> requester, request accepted when valid && ready
interface mdu_issue_if;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned DATA_W = 32;

   logic              req_valid;
   logic [OP_W-1:0]   req_op;
   logic [DATA_W-1:0] req_d1;
   logic [DATA_W-1:0] req_d2;
   logic              req_ready;

   modport master (
      output req_valid, req_op, req_d1, req_d2,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_op, req_d1, req_d2,
      output req_ready
   );
endinterface : mdu_issue_if

// File: rtl/mdu_issue.sv
// mdu_issue: one-entry holding stage between the E-stage and the multiply/
// divide unit. Holds a single request until the MDU is free, starts
// mult/multu/mthi/mtlo/div/divu, and returns mfhi/mflo results as a
// registered one-cycle rd_valid pulse.
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             drops the held request and refuses new ones this cycle
//   req (slave)       request channel: req_valid/req_op/req_d1/req_d2/req_ready
//   mdu_start/op/d1/d2  command to the MDU (driven while a request is held)
//   mdu_busy, mdu_out   MDU status and HI/LO read value
//   rd_data, rd_valid   registered mfhi/mflo result and its one-cycle pulse
//   stall             high while a request is held
//   dz_err            divide-by-zero pulse, only with MDU_DIVZERO_CHECK_EN
// Optional feature: define MDU_DIVZERO_CHECK_EN to drop div/divu with a zero
// divisor at acceptance and report it on dz_err; otherwise dz_err is tied 0.
module mdu_issue (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   mdu_issue_if.slave  req,
   output logic        mdu_start,
   output logic [3:0]  mdu_op,
   output logic [31:0] mdu_d1,
   output logic [31:0] mdu_d2,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_out,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        stall,
   output logic        dz_err
);
   localparam int unsigned OP_W   = 4;
   localparam int unsigned DATA_W = 32;

   localparam logic [OP_W-1:0] OP_MULT = OP_W'(1);
   localparam logic [OP_W-1:0] OP_MFHI = OP_W'(5);
   localparam logic [OP_W-1:0] OP_MFLO = OP_W'(6);
   localparam logic [OP_W-1:0] OP_DIV  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_DIVU = OP_W'(8);

   typedef enum logic [1:0] {IDLE, PEND, RDOUT} state_e;

   state_e            state_q;
   logic              pend_valid_q;
   logic [OP_W-1:0]   pend_op_q;
   logic [DATA_W-1:0] pend_d1_q;
   logic [DATA_W-1:0] pend_d2_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   logic accept;
   logic op_known;
   logic dz_hit;
   logic store;
   logic issue;
   logic pend_is_read;

   // Request acceptance; unknown opcodes are accepted but never stored
   assign req.req_ready = !pend_valid_q && !flush;
   assign accept        = req.req_valid && req.req_ready;
   assign op_known      = (req.req_op >= OP_MULT) && (req.req_op <= OP_DIVU);

`ifdef MDU_DIVZERO_CHECK_EN
   logic dz_err_q;

   // Zero-divisor divides are swallowed at acceptance and flagged next cycle
   assign dz_hit = accept && ((req.req_op == OP_DIV) || (req.req_op == OP_DIVU))
                   && (req.req_d2 == '0);
   assign dz_err = dz_err_q;

   always_ff @(posedge clk) begin
      if (reset) dz_err_q <= 1'b0;
      else       dz_err_q <= dz_hit;
   end
`else
   assign dz_hit = 1'b0;
   assign dz_err = 1'b0;
`endif

   assign store = accept && op_known && !dz_hit;

   // Issue whenever a request is held and the MDU can take it
   assign issue        = pend_valid_q && !mdu_busy && !flush;
   assign pend_is_read = (pend_op_q == OP_MFHI) || (pend_op_q == OP_MFLO);

   // mfhi/mflo only sample mdu_out; they never start the MDU
   assign mdu_start = issue && !pend_is_read;
   assign mdu_op    = pend_valid_q ? pend_op_q : '0;
   assign mdu_d1    = pend_valid_q ? pend_d1_q : '0;
   assign mdu_d2    = pend_valid_q ? pend_d2_q : '0;

   assign stall    = pend_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

   // Issue FSM with holding register and read-back capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pend_valid_q <= 1'b0;
         pend_op_q    <= '0;
         pend_d1_q    <= '0;
         pend_d2_q    <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            // RDOUT behaves like IDLE for new requests; the pulse is already out
            IDLE, RDOUT: begin
               if (store) begin
                  pend_valid_q <= 1'b1;
                  pend_op_q    <= req.req_op;
                  pend_d1_q    <= req.req_d1;
                  pend_d2_q    <= req.req_d2;
                  state_q      <= PEND;
               end else begin
                  state_q <= IDLE;
               end
            end
            PEND: begin
               if (flush) begin
                  pend_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end else if (issue) begin
                  pend_valid_q <= 1'b0;
                  if (pend_is_read) begin
                     rd_data_q  <= mdu_out;
                     rd_valid_q <= 1'b1;
                     state_q    <= RDOUT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               pend_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end
endmodule : mdu_issue

// File: tb/tb_mdu_issue.sv
// tb_mdu_issue: directed bench for mdu_issue. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later, mid-cycle.
module tb_mdu_issue;
   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        mdu_start;
   logic [3:0]  mdu_op;
   logic [31:0] mdu_d1;
   logic [31:0] mdu_d2;
   logic        mdu_busy;
   logic [31:0] mdu_out;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        stall;
   logic        dz_err;

   int errors = 0;
   int checks = 0;

   mdu_issue_if req_if ();

   mdu_issue dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req       (req_if),
      .mdu_start (mdu_start),
      .mdu_op    (mdu_op),
      .mdu_d1    (mdu_d1),
      .mdu_d2    (mdu_d2),
      .mdu_busy  (mdu_busy),
      .mdu_out   (mdu_out),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .stall     (stall),
      .dz_err    (dz_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic v, input logic [3:0] op,
                            input logic [31:0] d1, input logic [31:0] d2);
      req_if.req_valid = v;
      req_if.req_op    = op;
      req_if.req_d1    = d1;
      req_if.req_d2    = d2;
   endtask

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      mdu_busy = 1'b0;
      mdu_out  = 32'h0;
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      tick();
      tick();
      #1;
      chk("rst_stall",    32'(stall),     32'h0);
      chk("rst_start",    32'(mdu_start), 32'h0);
      chk("rst_rd_valid", 32'(rd_valid),  32'h0);
      chk("rst_rd_data",  rd_data,        32'h0);
      chk("rst_dz_err",   32'(dz_err),    32'h0);
      chk("rst_mdu_op",   32'(mdu_op),    32'h0);
      reset = 1'b0;

      // mult 3 * -2 from idle: accepted at edge N, issued in cycle N+1
      drive_req(1'b1, 4'd1, 32'd3, 32'hFFFF_FFFE);
      #1;
      chk("mult_ready", 32'(req_if.req_ready), 32'h1);
      chk("mult_start_early", 32'(mdu_start), 32'h0);
      tick();
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      chk("mult_start", 32'(mdu_start), 32'h1);
      chk("mult_op",    32'(mdu_op),    32'h1);
      chk("mult_d1",    mdu_d1,         32'd3);
      chk("mult_d2",    mdu_d2,         32'hFFFF_FFFE);
      chk("mult_stall", 32'(stall),     32'h1);
      chk("mult_ready_held", 32'(req_if.req_ready), 32'h0);
      tick();
      #1;
      chk("mult_start_done", 32'(mdu_start), 32'h0);
      chk("mult_stall_done", 32'(stall),     32'h0);
      chk("mult_op_idle",    32'(mdu_op),    32'h0);

      // mflo held while MDU busy for 4 cycles
      mdu_busy = 1'b1;
      mdu_out  = 32'hFFFF_FFFA;
      drive_req(1'b1, 4'd6, 32'h0, 32'h0);
      tick();
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("mflo_busy_stall", 32'(stall),     32'h1);
         chk("mflo_busy_start", 32'(mdu_start), 32'h0);
         tick();
      end
      mdu_busy = 1'b0;
      #1;
      chk("mflo_issue_start", 32'(mdu_start), 32'h0);
      chk("mflo_issue_op",    32'(mdu_op),    32'h6);
      chk("mflo_issue_rdv",   32'(rd_valid),  32'h0);
      tick();
      // rd_valid cycle; mthi presented here must be accepted
      drive_req(1'b1, 4'd3, 32'h0000_1234, 32'h0);
      #1;
      chk("mflo_rd_valid", 32'(rd_valid), 32'h1);
      chk("mflo_rd_data",  rd_data,       32'hFFFF_FFFA);
      chk("mflo_stall_off", 32'(stall),   32'h0);
      chk("rdout_ready",   32'(req_if.req_ready), 32'h1);
      tick();
      // mthi issue cycle; mfhi presented back-to-back
      mdu_out = 32'hCAFE_0001;
      drive_req(1'b1, 4'd5, 32'h0, 32'h0);
      #1;
      chk("mthi_start",     32'(mdu_start), 32'h1);
      chk("mthi_op",        32'(mdu_op),    32'h3);
      chk("mthi_d1",        mdu_d1,         32'h0000_1234);
      chk("mthi_rdv_off",   32'(rd_valid),  32'h0);
      chk("mthi_rd_hold",   rd_data,        32'hFFFF_FFFA);
      chk("mthi_ready_off", 32'(req_if.req_ready), 32'h0);
      tick();
      #1;
      chk("mfhi_ready",   32'(req_if.req_ready), 32'h1);
      chk("mfhi_no_start_idle", 32'(mdu_start), 32'h0);
      tick();
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      chk("mfhi_issue_start", 32'(mdu_start), 32'h0);
      chk("mfhi_issue_stall", 32'(stall),     32'h1);
      chk("mfhi_issue_op",    32'(mdu_op),    32'h5);
      tick();
      #1;
      chk("mfhi_rd_valid", 32'(rd_valid), 32'h1);
      chk("mfhi_rd_data",  rd_data,       32'hCAFE_0001);
      tick();
      #1;
      chk("mfhi_rdv_pulse", 32'(rd_valid), 32'h0);
      chk("mfhi_rd_hold",   rd_data,       32'hCAFE_0001);

      // flush while a divu is held
      mdu_busy = 1'b1;
      drive_req(1'b1, 4'd8, 32'd100, 32'd7);
      tick();
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      chk("divu_held_stall", 32'(stall),     32'h1);
      chk("divu_held_start", 32'(mdu_start), 32'h0);
      tick();
      flush    = 1'b1;
      mdu_busy = 1'b0;
      drive_req(1'b1, 4'd1, 32'd5, 32'd5);
      #1;
      chk("flush_ready", 32'(req_if.req_ready), 32'h0);
      chk("flush_start", 32'(mdu_start),        32'h0);
      tick();
      flush = 1'b0;
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      chk("flush_cleared", 32'(stall),     32'h0);
      chk("flush_no_start", 32'(mdu_start), 32'h0);
      chk("flush_op_zero", 32'(mdu_op),    32'h0);

      // reset while a div is pending
      mdu_busy = 1'b1;
      drive_req(1'b1, 4'd7, 32'd7, 32'd2);
      tick();
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      chk("div_pend_stall", 32'(stall), 32'h1);
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      mdu_busy = 1'b0;
      #1;
      chk("rst_mid_stall",   32'(stall),     32'h0);
      chk("rst_mid_start",   32'(mdu_start), 32'h0);
      chk("rst_mid_op",      32'(mdu_op),    32'h0);
      chk("rst_mid_rd_data", rd_data,        32'h0);
      chk("rst_mid_rdv",     32'(rd_valid),  32'h0);
      tick();
      #1;
      chk("rst_mid_start2",  32'(mdu_start), 32'h0);

      // unknown opcodes 0 and 9 are accepted with no effect
      drive_req(1'b1, 4'd9, 32'h1, 32'h1);
      #1;
      chk("op9_ready", 32'(req_if.req_ready), 32'h1);
      tick();
      drive_req(1'b1, 4'd0, 32'h1, 32'h1);
      #1;
      chk("op9_no_stall", 32'(stall),     32'h0);
      chk("op9_no_start", 32'(mdu_start), 32'h0);
      tick();
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      chk("op0_no_stall", 32'(stall), 32'h0);

      // div 7 / 0
      drive_req(1'b1, 4'd7, 32'd7, 32'd0);
      tick();
      drive_req(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
`ifdef MDU_DIVZERO_CHECK_EN
      chk("dz_err_pulse", 32'(dz_err),    32'h1);
      chk("dz_no_start",  32'(mdu_start), 32'h0);
      chk("dz_no_stall",  32'(stall),     32'h0);
      tick();
      #1;
      chk("dz_err_end",   32'(dz_err),    32'h0);
`else
      chk("dz_start",     32'(mdu_start), 32'h1);
      chk("dz_op",        32'(mdu_op),    32'h7);
      chk("dz_d2",        mdu_d2,         32'h0);
      chk("dz_err_tied",  32'(dz_err),    32'h0);
      tick();
      #1;
      chk("dz_done",      32'(stall),     32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule : tb_mdu_issue
